// File: rtl/wb_c_uart.sv
// Wishbone character-bus UART: 8N1 console with TX/RX byte FIFOs, STATUS register and an
// RX-non-empty level interrupt.
module wb_c_uart #(
    parameter int unsigned CLK_DIV = 868,
    parameter int unsigned FIFO_AW = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_c_stb_i,
    input  logic        wb_c_we_i,
    input  logic [31:0] wb_c_adr_i,
    input  logic [7:0]  wb_c_dat_i,
    output logic [7:0]  wb_c_dat_o,
    output logic        wb_c_ack_o,
    output logic        wb_c_err_o,
    output logic        wb_c_rty_o,
    input  logic        uart_rxd_i,
    output logic        uart_txd_o,
    output logic        irq_o
);

    localparam int unsigned Depth = 1 << FIFO_AW;
    localparam logic [15:0] BitLast = 16'(CLK_DIV - 1);
    localparam logic [15:0] HalfLast = 16'(CLK_DIV / 2 - 1);
    localparam logic [FIFO_AW:0] PtrOne = {{FIFO_AW{1'b0}}, 1'b1};

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StStart = 2'd1;
    localparam logic [1:0] StData  = 2'd2;
    localparam logic [1:0] StStop  = 2'd3;

    logic unused_bits;
    assign unused_bits = ^{wb_c_adr_i[31:3], wb_c_adr_i[1:0]};

    // ---------------------------------------------------------------- bus decode
    logic ack_q, ack_d;
    logic [7:0] dat_q, dat_d;
    logic sel_stat, wr_data, rd_data, clr_ovr;

    assign ack_d    = wb_c_stb_i & ~ack_q;
    assign sel_stat = wb_c_adr_i[2];
    assign wr_data  = ack_d & wb_c_we_i & ~sel_stat;
    assign rd_data  = ack_d & ~wb_c_we_i & ~sel_stat;
    assign clr_ovr  = ack_d & wb_c_we_i & sel_stat & wb_c_dat_i[2];

    // ---------------------------------------------------------------- FIFO storage
    logic [7:0] tx_mem_q [Depth];
    logic [7:0] rx_mem_q [Depth];
    logic [FIFO_AW:0] tx_wptr_q, tx_rptr_q, rx_wptr_q, rx_rptr_q;
    logic tx_full, tx_empty, rx_full, rx_empty;
    logic tx_push, tx_pop, rx_push, rx_pop;

    assign tx_empty = tx_wptr_q == tx_rptr_q;
    assign tx_full  = (tx_wptr_q[FIFO_AW] != tx_rptr_q[FIFO_AW]) &&
                      (tx_wptr_q[FIFO_AW-1:0] == tx_rptr_q[FIFO_AW-1:0]);
    assign rx_empty = rx_wptr_q == rx_rptr_q;
    assign rx_full  = (rx_wptr_q[FIFO_AW] != rx_rptr_q[FIFO_AW]) &&
                      (rx_wptr_q[FIFO_AW-1:0] == rx_rptr_q[FIFO_AW-1:0]);

    assign tx_push = wr_data & ~tx_full;
    assign rx_pop  = rd_data & ~rx_empty;

    // ---------------------------------------------------------------- TX engine
    logic [1:0]  tx_st_q, tx_st_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [7:0]  tx_sh_q, tx_sh_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic        txd_q, txd_d;
    logic        tx_load;

    // A new byte may start straight out of the last stop-bit cycle, so frames abut.
    assign tx_load = ~tx_empty & ((tx_st_q == StIdle) ||
                                  (tx_st_q == StStop && tx_cnt_q == 16'd0));
    assign tx_pop  = tx_load;

    always_comb begin
        tx_st_d  = tx_st_q;
        tx_cnt_d = tx_cnt_q;
        tx_sh_d  = tx_sh_q;
        tx_bit_d = tx_bit_q;
        txd_d    = txd_q;
        if (tx_st_q != StIdle && tx_cnt_q != 16'd0) begin
            tx_cnt_d = tx_cnt_q - 16'd1;
        end
        case (tx_st_q)
            StStart: begin
                if (tx_cnt_q == 16'd0) begin
                    tx_st_d  = StData;
                    tx_cnt_d = BitLast;
                    txd_d    = tx_sh_q[0];
                    tx_sh_d  = {1'b0, tx_sh_q[7:1]};
                    tx_bit_d = 3'd0;
                end
            end
            StData: begin
                if (tx_cnt_q == 16'd0) begin
                    tx_cnt_d = BitLast;
                    if (tx_bit_q == 3'd7) begin
                        tx_st_d = StStop;
                        txd_d   = 1'b1;
                    end else begin
                        txd_d    = tx_sh_q[0];
                        tx_sh_d  = {1'b0, tx_sh_q[7:1]};
                        tx_bit_d = tx_bit_q + 3'd1;
                    end
                end
            end
            StStop: begin
                if (tx_cnt_q == 16'd0) begin
                    tx_st_d = StIdle;
                end
            end
            default: ;
        endcase
        if (tx_load) begin
            tx_st_d  = StStart;
            tx_cnt_d = BitLast;
            tx_sh_d  = tx_mem_q[tx_rptr_q[FIFO_AW-1:0]];
            txd_d    = 1'b0;
        end
    end

    // ---------------------------------------------------------------- RX engine
    logic        rx_s1_q, rx_s2_q;
    logic [1:0]  rx_st_q, rx_st_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [7:0]  rx_sh_q, rx_sh_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic        rx_done;

    assign rx_done = (rx_st_q == StStop) && (rx_cnt_q == 16'd0) && rx_s2_q;
    assign rx_push = rx_done & ~rx_full;

    always_comb begin
        rx_st_d  = rx_st_q;
        rx_cnt_d = rx_cnt_q;
        rx_sh_d  = rx_sh_q;
        rx_bit_d = rx_bit_q;
        if (rx_st_q != StIdle && rx_cnt_q != 16'd0) begin
            rx_cnt_d = rx_cnt_q - 16'd1;
        end
        case (rx_st_q)
            StIdle: begin
                if (!rx_s2_q) begin
                    rx_st_d  = StStart;
                    rx_cnt_d = HalfLast;
                end
            end
            StStart: begin
                if (rx_cnt_q == 16'd0) begin
                    if (!rx_s2_q) begin
                        rx_st_d  = StData;
                        rx_cnt_d = BitLast;
                        rx_bit_d = 3'd0;
                    end else begin
                        rx_st_d = StIdle;
                    end
                end
            end
            StData: begin
                if (rx_cnt_q == 16'd0) begin
                    rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
                    rx_cnt_d = BitLast;
                    if (rx_bit_q == 3'd7) begin
                        rx_st_d = StStop;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end
            end
            default: begin
                if (rx_cnt_q == 16'd0) begin
                    rx_st_d = StIdle;
                end
            end
        endcase
    end

    // ---------------------------------------------------------------- status / read data
    logic ovr_q, ovr_d;
    logic irq_q, irq_d;
    logic tx_idle;
    logic [7:0] status;

    assign tx_idle = tx_empty & (tx_st_q == StIdle);
    assign status  = {4'b0000, tx_idle, ovr_q, tx_full, ~rx_empty};
    // A new overrun in the same cycle as a clear must stick.
    assign ovr_d   = (rx_done & rx_full) | (ovr_q & ~clr_ovr);
    assign irq_d   = ~rx_empty;

    always_comb begin
        dat_d = 8'h00;
        if (ack_d && !wb_c_we_i) begin
            if (sel_stat) begin
                dat_d = status;
            end else if (!rx_empty) begin
                dat_d = rx_mem_q[rx_rptr_q[FIFO_AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem_q[tx_wptr_q[FIFO_AW-1:0]] <= wb_c_dat_i;
        end
        if (rx_push) begin
            rx_mem_q[rx_wptr_q[FIFO_AW-1:0]] <= rx_sh_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q     <= 1'b0;
            dat_q     <= 8'h00;
            tx_wptr_q <= '0;
            tx_rptr_q <= '0;
            rx_wptr_q <= '0;
            rx_rptr_q <= '0;
            tx_st_q   <= StIdle;
            tx_cnt_q  <= 16'd0;
            tx_sh_q   <= 8'h00;
            tx_bit_q  <= 3'd0;
            txd_q     <= 1'b1;
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_st_q   <= StIdle;
            rx_cnt_q  <= 16'd0;
            rx_sh_q   <= 8'h00;
            rx_bit_q  <= 3'd0;
            ovr_q     <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            ack_q     <= ack_d;
            dat_q     <= dat_d;
            if (tx_push) tx_wptr_q <= tx_wptr_q + PtrOne;
            if (tx_pop)  tx_rptr_q <= tx_rptr_q + PtrOne;
            if (rx_push) rx_wptr_q <= rx_wptr_q + PtrOne;
            if (rx_pop)  rx_rptr_q <= rx_rptr_q + PtrOne;
            tx_st_q   <= tx_st_d;
            tx_cnt_q  <= tx_cnt_d;
            tx_sh_q   <= tx_sh_d;
            tx_bit_q  <= tx_bit_d;
            txd_q     <= txd_d;
            rx_s1_q   <= uart_rxd_i;
            rx_s2_q   <= rx_s1_q;
            rx_st_q   <= rx_st_d;
            rx_cnt_q  <= rx_cnt_d;
            rx_sh_q   <= rx_sh_d;
            rx_bit_q  <= rx_bit_d;
            ovr_q     <= ovr_d;
            irq_q     <= irq_d;
        end
    end

    assign wb_c_ack_o = ack_q;
    assign wb_c_dat_o = dat_q;
    assign wb_c_err_o = 1'b0;
    assign wb_c_rty_o = 1'b0;
    assign uart_txd_o = txd_q;
    assign irq_o      = irq_q;

endmodule

// File: tb/tb_wb_c_uart.sv
// Bench for wb_c_uart: queue-based model of FIFOs, serial line and status, checked every
// cycle, plus directed bus/serial sequences with literal expectations.
module tb_wb_c_uart;

    localparam int unsigned ClkDiv = 4;
    localparam int unsigned FifoAw = 2;
    localparam int unsigned Depth  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stb = 1'b0;
    logic        we = 1'b0;
    logic [31:0] adr = 32'hC000_0000;
    logic [7:0]  dat_i = 8'h00;
    logic [7:0]  dat_o;
    logic        ack, err, rty;
    logic        rxd = 1'b1;
    logic        txd, irq;

    always #5 clk = ~clk;

    wb_c_uart #(.CLK_DIV(ClkDiv), .FIFO_AW(FifoAw)) dut (
        .clk        (clk),
        .rst        (rst),
        .wb_c_stb_i (stb),
        .wb_c_we_i  (we),
        .wb_c_adr_i (adr),
        .wb_c_dat_i (dat_i),
        .wb_c_dat_o (dat_o),
        .wb_c_ack_o (ack),
        .wb_c_err_o (err),
        .wb_c_rty_o (rty),
        .uart_rxd_i (rxd),
        .uart_txd_o (txd),
        .irq_o      (irq)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%02h, want 0x%02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b, want %b at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------ behavioural model
    logic [7:0] tx_pend[$];
    logic       line_q[$];
    logic [7:0] rx_q[$];
    logic       m_ovr = 1'b0;
    logic       m_ack = 1'b0;
    logic       chk_irq = 1'b1;

    function automatic logic [7:0] m_status();
        logic idle;
        idle = (tx_pend.size() == 0) && (line_q.size() == 0);
        return {4'b0000, idle, m_ovr, tx_pend.size() == Depth, rx_q.size() != 0};
    endfunction

    initial begin
        logic s_rst, s_stb, s_we, s_a2, exp_ack, exp_txd;
        logic [7:0] s_dat, exp_d, b;
        logic [9:0] fr;
        forever begin
            @(posedge clk);
            s_rst = rst; s_stb = stb; s_we = we; s_a2 = adr[2]; s_dat = dat_i;
            @(negedge clk);
            check1("err_o", err, 1'b0);
            check1("rty_o", rty, 1'b0);
            if (s_rst) begin
                tx_pend.delete(); line_q.delete(); rx_q.delete();
                m_ovr = 1'b0; m_ack = 1'b0;
                check1("ack_rst", ack, 1'b0);
                check1("txd_rst", txd, 1'b1);
                check1("irq_rst", irq, 1'b0);
                check8("dat_rst", dat_o, 8'h00);
            end else begin
                exp_ack = s_stb & ~m_ack;
                m_ack = exp_ack;
                check1("ack", ack, exp_ack);
                if (chk_irq) check1("irq", irq, rx_q.size() != 0);
                if (exp_ack) begin
                    if (!s_we) begin
                        exp_d = s_a2 ? m_status() : (rx_q.size() != 0 ? rx_q[0] : 8'h00);
                        check8("dat_o", dat_o, exp_d);
                        if (!s_a2 && rx_q.size() != 0) void'(rx_q.pop_front());
                    end else if (!s_a2) begin
                        if (tx_pend.size() < Depth) tx_pend.push_back(s_dat);
                    end else if (s_dat[2]) begin
                        m_ovr = 1'b0;
                    end
                end
                exp_txd = (line_q.size() != 0) ? line_q.pop_front() : 1'b1;
                check1("txd", txd, exp_txd);
                if (line_q.size() == 0 && tx_pend.size() != 0) begin
                    b = tx_pend.pop_front();
                    fr = {1'b1, b, 1'b0};
                    for (int k = 0; k < 10; k++) begin
                        repeat (ClkDiv) line_q.push_back(fr[k]);
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------ stimulus helpers
    task automatic bus(input logic w, input logic a2, input logic [7:0] d,
                       output logic [7:0] rdat);
        int lat;
        logic got;
        @(posedge clk); #1;
        stb = 1'b1; we = w; dat_i = d;
        adr = a2 ? 32'hC000_0004 : 32'hC000_0000;
        got = 1'b0; lat = 0; rdat = 8'h00;
        for (int i = 1; i <= 20 && !got; i++) begin
            @(posedge clk); #1;
            if (ack) begin
                got = 1'b1; lat = i; rdat = dat_o;
            end
        end
        stb = 1'b0; we = 1'b0;
        if (!got) begin
            n_checks++; n_errors++;
            $display("FAIL bus_timeout: got no ack, want ack within 20 cycles");
        end else begin
            check8("ack_latency", 8'(lat), 8'd1);
        end
    endtask

    task automatic rd_expect(input string name, input logic a2, input logic [7:0] exp);
        logic [7:0] r;
        bus(1'b0, a2, 8'h00, r);
        check8(name, r, exp);
    endtask

    task automatic wr(input logic a2, input logic [7:0] d);
        logic [7:0] r;
        bus(1'b1, a2, d, r);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        chk_irq = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            rxd = fr[i];
            repeat (ClkDiv) begin @(posedge clk); #1; end
        end
        rxd = 1'b1;
        repeat (6) begin @(posedge clk); #1; end
        if (stop_bit) begin
            if (rx_q.size() == Depth) m_ovr = 1'b1;
            else rx_q.push_back(b);
        end
        chk_irq = 1'b1;
    endtask

    // ------------------------------------------------------------ directed sequence
    initial begin
        logic [9:0] pat;
        pat = 10'b10_1010_1010;  // 0x55 frame, start bit in bit 0
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        rd_expect("status_after_reset", 1'b1, 8'h08);
        check1("txd_idle", txd, 1'b1);
        check1("irq_idle", irq, 1'b0);

        wr(1'b0, 8'h55);
        repeat (3) @(posedge clk);
        for (int k = 0; k < 10; k++) begin
            #1 check1("tx55_bit", txd, pat[k]);
            repeat (ClkDiv) @(posedge clk);
        end
        repeat (4) @(posedge clk);
        rd_expect("status_tx_done", 1'b1, 8'h08);

        for (int i = 1; i <= 5; i++) wr(1'b0, 8'(i));
        rd_expect("status_tx_full", 1'b1, 8'h02);
        wr(1'b0, 8'h06);
        repeat (230) @(posedge clk);
        rd_expect("status_burst_done", 1'b1, 8'h08);

        send_frame(8'hA3, 1'b1);
        check1("irq_rx", irq, 1'b1);
        rd_expect("status_rx", 1'b1, 8'h09);
        rd_expect("rx_a3", 1'b0, 8'hA3);
        @(posedge clk); #1;
        check1("irq_after_pop", irq, 1'b0);
        rd_expect("rx_empty_read", 1'b0, 8'h00);

        send_frame(8'h10, 1'b1);
        send_frame(8'h21, 1'b1);
        send_frame(8'h32, 1'b1);
        send_frame(8'h43, 1'b1);
        send_frame(8'h54, 1'b1);
        rd_expect("status_overrun", 1'b1, 8'h0D);
        rd_expect("rx_b0", 1'b0, 8'h10);
        rd_expect("rx_b1", 1'b0, 8'h21);
        rd_expect("rx_b2", 1'b0, 8'h32);
        rd_expect("rx_b3", 1'b0, 8'h43);
        rd_expect("status_ovr_sticky", 1'b1, 8'h0C);
        wr(1'b1, 8'h04);
        rd_expect("status_ovr_clr", 1'b1, 8'h08);

        @(posedge clk); #1 rxd = 1'b0;
        @(posedge clk); #1 rxd = 1'b1;
        repeat (10) @(posedge clk);
        #1 check1("irq_glitch", irq, 1'b0);
        send_frame(8'h5A, 1'b0);
        repeat (10) @(posedge clk);
        #1 check1("irq_framing", irq, 1'b0);
        rd_expect("status_framing", 1'b1, 8'h08);

        wr(1'b0, 8'hF0);
        wr(1'b0, 8'h0F);
        repeat (15) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        check1("txd_after_rst", txd, 1'b1);
        rst = 1'b0;
        rd_expect("status_after_rst", 1'b1, 8'h08);
        repeat (60) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, want finished");
        $fatal(1, "watchdog");
    end

endmodule
